// File: rtl/aligned_ram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : aligned_ram_arbiter_if                                      |
// | Brief  : Two-requester request/response bundle for the arbiter.      |
// |          Requester i occupies bit i of the per-requester vectors and |
// |          slice i of the packed address/data buses.                   |
// | Ports  : master = requester side, slave = arbiter side               |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface aligned_ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/aligned_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : aligned_ram_arbiter                                         |
// | Brief  : Round-robin arbiter and access sequencer in front of a      |
// |          word-aligned single-port RAM. One request in flight; bad    |
// |          addresses are answered with an error and never reach RAM.  |
// | Ports  : clk, rst      - clock, synchronous active-high reset        |
// |          bus (slave)   - two-requester request/response channel      |
// |          ram_*         - RAM port (read data valid cycle after en)   |
// |          busy          - transaction in progress                     |
// |          err_cnt       - saturating count of rejected requests       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module aligned_ram_arbiter #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 256,
  localparam int RAM_AW = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  aligned_ram_arbiter_if.slave   bus,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  input  wire logic [DATA_W-1:0] ram_rdata,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_rr_last;
  logic                r_gnt_id;
  logic                r_we;
  logic [RAM_AW-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rsp_valid;
  logic                r_rsp_err;
  logic                r_ram_en;
  logic                r_ram_we;
  logic                r_busy;
  logic [7:0]          r_err_cnt;

  logic [1:0]          w_grant;
  logic [1:0]          w_ready;
  logic                w_sel;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_sel_we;
  logic                w_bad;

  // Round robin: with both valid, the requester not served last wins.
  // rr_last resets to 1 so requester 0 wins the first tie.
  always_comb begin
    w_grant[0] = bus.req_valid[0] & (~bus.req_valid[1] | r_rr_last);
    w_grant[1] = bus.req_valid[1] & (~bus.req_valid[0] | ~r_rr_last);
  end

  // Grants only leave the arbiter in IDLE and never while reset is held,
  // so a handshake can never be seen by the requester and lost here.
  assign w_ready     = (r_state == S_IDLE && !rst) ? w_grant : 2'b00;
  assign w_sel       = w_ready[1];
  assign w_sel_addr  = w_sel ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
  assign w_sel_wdata = w_sel ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
  assign w_sel_we    = w_sel ? bus.req_we[1] : bus.req_we[0];
  assign w_bad       = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr[ADDR_W-1:2] >= DEPTH_WORDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_last   <= 1'b1;
      r_gnt_id    <= 1'b0;
      r_we        <= 1'b0;
      r_ram_addr  <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ready != 2'b00) begin
            r_gnt_id   <= w_sel;
            r_rr_last  <= w_sel;
            r_we       <= w_sel_we;
            r_ram_addr <= w_sel_addr[RAM_AW+1:2];
            r_wdata    <= w_sel_wdata;
            r_busy     <= 1'b1;
            if (w_bad) begin
              // Rejected: straight to the response, RAM untouched.
              r_rsp_valid <= w_ready;
              r_rsp_err   <= 1'b1;
              if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
              end
              r_state <= S_RESP;
            end else begin
              r_ram_en <= 1'b1;
              r_ram_we <= w_sel_we;
              r_state  <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          if (r_we) begin
            r_rsp_valid <= {r_gnt_id, ~r_gnt_id};
            r_state     <= S_RESP;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_rdata     <= ram_rdata;
          r_rsp_valid <= {r_gnt_id, ~r_gnt_id};
          r_state     <= S_RESP;
        end
        S_RESP: begin
          // Only the granted requester's ready can retire the response.
          if (bus.rsp_ready[r_gnt_id]) begin
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  // r_rdata is loaded only on the CAPTURE->RESP edge and cleared on exit,
  // so it is zero for writes, errors and outside RESP.
  assign bus.rsp_rdata = r_rdata;
  assign ram_en        = r_ram_en;
  assign ram_we        = r_ram_we;
  assign ram_addr      = r_ram_addr;
  assign ram_wdata     = r_wdata;
  assign busy          = r_busy;
  assign err_cnt       = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aligned_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_aligned_ram_arbiter                                      |
// | Brief  : Directed self-checking bench for aligned_ram_arbiter with a |
// |          behavioural single-port RAM (one-cycle read latency).       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_aligned_ram_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int RAM_AW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ram_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic [7:0]        err_cnt;

  int checks = 0;
  int errors = 0;

  aligned_ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  aligned_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_g;
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
    chk("rst_ram_addr", ram_addr, 8'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);

    // Requester 0 writes 0xDEADBEEF to byte address 0x10 (word 4).
    bus.req_we    = 2'b01;
    bus.req_addr  = {32'h0, 32'h10};
    bus.req_wdata = {32'h0, 32'hDEADBEEF};
    bus.req_valid = 2'b01;
    #1;
    chk("wr_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    chk("wr_ram_en", ram_en, 1'b1);
    chk("wr_ram_we", ram_we, 1'b1);
    chk("wr_ram_addr", ram_addr, 8'd4);
    chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    chk("wr_busy", busy, 1'b1);
    chk("wr_rsp_early", bus.rsp_valid, 2'b00);
    tick();
    chk("wr_rsp_valid", bus.rsp_valid, 2'b01);
    chk("wr_rsp_err", bus.rsp_err, 1'b0);
    chk("wr_ram_en_off", ram_en, 1'b0);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
    chk("wr_rsp_done", bus.rsp_valid, 2'b00);
    chk("wr_idle", busy, 1'b0);

    // Requester 1 reads word 4 back.
    bus.req_we    = 2'b00;
    bus.req_addr  = {32'h10, 32'h0};
    bus.req_valid = 2'b10;
    #1;
    chk("rd_req_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    chk("rd_ram_en", ram_en, 1'b1);
    chk("rd_ram_we", ram_we, 1'b0);
    chk("rd_ram_addr", ram_addr, 8'd4);
    tick();
    chk("rd_capture_no_rsp", bus.rsp_valid, 2'b00);
    tick();
    chk("rd_rsp_valid", bus.rsp_valid, 2'b10);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err", bus.rsp_err, 1'b0);
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;
    chk("rd_rsp_done", bus.rsp_valid, 2'b00);

    // Misaligned write from requester 0.
    bus.req_we    = 2'b01;
    bus.req_addr  = {32'h0, 32'h13};
    bus.req_valid = 2'b01;
    #1;
    chk("mis_req_ready", bus.req_ready, 2'b01);
    tick();
    bus.req_valid = 2'b00;
    chk("mis_rsp_valid", bus.rsp_valid, 2'b01);
    chk("mis_rsp_err", bus.rsp_err, 1'b1);
    chk("mis_ram_en", ram_en, 1'b0);
    chk("mis_rdata", bus.rsp_rdata, 32'd0);
    chk("mis_err_cnt", err_cnt, 8'd1);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;

    // Out of range: DEPTH*4 = 0x400.
    bus.req_addr  = {32'h0, 32'h400};
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    chk("oor_rsp_valid", bus.rsp_valid, 2'b01);
    chk("oor_rsp_err", bus.rsp_err, 1'b1);
    chk("oor_ram_en", ram_en, 1'b0);
    chk("oor_err_cnt", err_cnt, 8'd2);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;

    // Last legal word, DEPTH*4-4 = 0x3FC.
    bus.req_addr  = {32'h0, 32'h3FC};
    bus.req_wdata = {32'h0, 32'h12345678};
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    chk("top_ram_en", ram_en, 1'b1);
    chk("top_ram_addr", ram_addr, 8'd255);
    tick();
    chk("top_rsp_valid", bus.rsp_valid, 2'b01);
    chk("top_rsp_err", bus.rsp_err, 1'b0);
    chk("top_err_cnt", err_cnt, 8'd2);
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;

    // Round robin with both requesters continuously valid after reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_we    = 2'b00;
    bus.req_addr  = {32'h10, 32'h10};
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = ((k % 2) == 0) ? 2'b01 : 2'b10;
      #1;
      chk("rr_grant", bus.req_ready, exp_g);
      tick();
      chk("rr_ready_access", bus.req_ready, 2'b00);
      tick();
      chk("rr_ready_capture", bus.req_ready, 2'b00);
      tick();
      chk("rr_rsp_valid", bus.rsp_valid, exp_g);
      chk("rr_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      // Ready from the other requester must not retire the response.
      bus.rsp_ready = ~exp_g;
      for (int h = 0; h < 3; h++) begin
        tick();
        chk("rr_hold_valid", bus.rsp_valid, exp_g);
        chk("rr_hold_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("rr_hold_ready", bus.req_ready, 2'b00);
      end
      bus.rsp_ready = exp_g;
      tick();
      bus.rsp_ready = 2'b00;
      chk("rr_rsp_done", bus.rsp_valid, 2'b00);
    end
    bus.req_valid = 2'b00;

    // Reset while a read is in ACCESS.
    bus.req_addr  = {32'h0, 32'h10};
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    chk("mid_access", ram_en, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_ram_en", ram_en, 1'b0);
    chk("mid_ram_we", ram_we, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_rsp_valid", bus.rsp_valid, 2'b00);
    chk("mid_req_ready", bus.req_ready, 2'b00);
    chk("mid_ram_addr", ram_addr, 8'd0);
    chk("mid_rsp_err", bus.rsp_err, 1'b0);
    chk("mid_err_cnt", err_cnt, 8'd0);
    bus.rsp_ready = 2'b11;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mid_no_rsp", bus.rsp_valid, 2'b00);
      chk("mid_no_ram", ram_en, 1'b0);
    end
    bus.rsp_ready = 2'b00;
    bus.req_we    = 2'b10;
    bus.req_addr  = {32'h20, 32'h0};
    bus.req_wdata = {32'hA5A5A5A5, 32'h0};
    bus.req_valid = 2'b10;
    #1;
    chk("post_req_ready", bus.req_ready, 2'b10);
    tick();
    bus.req_valid = 2'b00;
    chk("post_ram_en", ram_en, 1'b1);
    chk("post_ram_addr", ram_addr, 8'd8);
    chk("post_ram_wdata", ram_wdata, 32'hA5A5A5A5);
    tick();
    chk("post_rsp_valid", bus.rsp_valid, 2'b10);
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;

    // 300 misaligned requests: counter saturates at 255.
    bus.req_we   = 2'b00;
    bus.req_addr = {32'h0, 32'h1};
    for (int i = 0; i < 300; i++) begin
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b01;
      tick();
      bus.rsp_ready = 2'b00;
      if (i == 253) chk("sat_254", err_cnt, 8'd254);
      if (i == 254) chk("sat_255", err_cnt, 8'd255);
    end
    chk("sat_hold", err_cnt, 8'd255);
    chk("sat_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
